// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the multi-cycle shift sequencer.
// Op codes and FSM state type.
package shift_seq_ctrl_pkg;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shift_seq_ctrl_shift_stage.sv
// One power-of-two shift stage, reused every SHIFT cycle.
// Shifts data by 2^k according to op; reserved op passes through.
module shift_stage
   import shift_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic [WIDTH-1:0] data,
   input  logic [1:0]       op,
   input  logic [2:0]       k,
   output logic [WIDTH-1:0] q
);

   logic [SHW-1:0] amt;

   assign amt = SHW'(1) << k;

   // select the stage flavour; SRA replicates the current MSB
   always_comb begin
      q = data;
      unique case (1'b1)
         (op == OP_SLL): q = data << amt;
         (op == OP_SRL): q = data >> amt;
         (op == OP_SRA): q = $signed(data) >>> amt;
         default:        q = data;
      endcase
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: one power-of-two stage per clock,
// skipping zero bits of the amount, valid/ready on both sides.
module shift_seq_ctrl
   import shift_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             busy
);

   state_t           state;
   logic [WIDTH-1:0] data_r;
   logic [WIDTH-1:0] stage_q;
   logic [SHW-1:0]   rem_r;
   logic [SHW-1:0]   rem_nx;
   logic [1:0]       op_r;
   logic [2:0]       k;
   logic             unused_a;

   assign unused_a = ^A[WIDTH-1:SHW];

   // highest set bit of the remaining amount picks this cycle's stage
   always_comb begin
      k = '0;
      for (int i = 0; i < SHW; i++)
         if (rem_r[i]) k = 3'(i);
   end

   assign rem_nx = rem_r & ~(SHW'(1) << k);

   shift_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_stage (
      .data (data_r),
      .op   (op_r),
      .k    (k),
      .q    (stage_q)
   );

   // sequencer FSM with registered handshake outputs and result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         data_r    <= '0;
         rem_r     <= '0;
         op_r      <= '0;
         res       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else if (flush) begin
         state     <= S_IDLE;
         rem_r     <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  data_r   <= B;
                  rem_r    <= A[SHW-1:0];
                  op_r     <= op;
                  busy     <= 1'b1;
                  in_ready <= 1'b0;
                  if (A[SHW-1:0] == '0 || op == OP_RSV) begin
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                     res       <= B;
                  end else begin
                     state <= S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               data_r <= stage_q;
               rem_r  <= rem_nx;
               if (rem_nx == '0) begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
                  res       <= stage_q;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: directed plan cases,
// backpressure, flush, async reset, then random requests.
module tb_shift_seq_ctrl;
   import shift_seq_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] res;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] r;
      int          t;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   bit          rdy_rand = 1'b0;
   bit          rdy_force = 1'b1;
   logic        prev_ov = 1'b0;
   logic [31:0] prev_res = '0;

   shift_seq_ctrl u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      #2;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
   end

   function automatic logic [31:0] model(logic [1:0] o,
                                         logic [31:0] a,
                                         logic [31:0] b);
      int s = int'(a[4:0]);
      case (o)
         2'b00:   return b << s;
         2'b01:   return b >> s;
         2'b10:   return $signed(b) >>> s;
         default: return b;
      endcase
   endfunction

   function automatic int lat(logic [1:0] o, logic [31:0] a);
      if (o == 2'b11 || a[4:0] == 5'd0) return 0;
      return $countones(a[4:0]);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic timeout(string name);
      checks++;
      errors++;
      $display("FAIL %s got timeout want event", name);
   endtask

   task automatic send(logic [1:0] o, logic [31:0] a,
                       logic [31:0] b, logic [31:0] e);
      int   n = 0;
      exp_t x;
      @(negedge clk);
      in_valid = 1'b1;
      op = o;
      A = a;
      B = b;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         timeout("accept");
         in_valid = 1'b0;
         return;
      end
      x.r = e;
      x.t = cyc + lat(o, a) + 1;
      sb.push_back(x);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = 2'($urandom);
      A = $urandom;
      B = $urandom;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0 || !in_ready) timeout("drain");
   endtask

   // result monitor: pops the scoreboard on each new result
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov = 1'b0;
      end else begin
         if (out_valid) chk("ready_in_done", 32'(in_ready), 32'd0);
         if (out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result got %h want none", res);
            end else begin
               mon_e = sb.pop_front();
               chk("res", res, mon_e.r);
               chk("latency", 32'(cyc), 32'(mon_e.t));
            end
         end else if (out_valid && prev_ov) begin
            chk("res_hold", res, prev_res);
         end
         prev_ov = out_valid;
         prev_res = res;
      end
   end

   initial begin
      int n;
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      rst_n = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      op = '0;
      A = '0;
      B = '0;
      repeat (2) @(negedge clk);
      chk("rst_res", res, 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      send(OP_SRL, 32'hABCD_EF1F, 32'h8000_0000, 32'h0000_0001);
      send(OP_SRA, 32'd4, 32'hF000_0000, 32'hFF00_0000);
      send(OP_SRA, 32'd4, 32'h7000_0000, 32'h0700_0000);
      send(OP_SLL, 32'd8, 32'h0000_00FF, 32'h0000_FF00);
      send(OP_SLL, 32'hFFFF_FFE0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      send(OP_RSV, 32'd5, 32'hCAFE_F00D, 32'hCAFE_F00D);
      drain();

      rdy_force = 1'b0;
      send(OP_SLL, 32'd8, 32'h0000_00FF, 32'h0000_FF00);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) timeout("bp_valid");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         in_valid = 1'b1;
         op = OP_SRL;
         A = 32'd3;
         B = $urandom;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rdy_force = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", 32'(out_valid), 32'd0);
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      drain();

      rb = $urandom;
      send(OP_SRL, 32'd31, rb, model(OP_SRL, 32'd31, rb));
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      sb.delete();
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      repeat (10) @(negedge clk);

      @(negedge clk);
      in_valid = 1'b1;
      flush = 1'b1;
      op = OP_SLL;
      A = 32'd1;
      B = 32'h5555_5555;
      @(negedge clk);
      in_valid = 1'b0;
      flush = 1'b0;
      chk("flush_idle_ready", 32'(in_ready), 32'd1);
      chk("flush_idle_busy", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);

      rb = $urandom;
      send(OP_SRL, 32'd31, rb, model(OP_SRL, 32'd31, rb));
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_res", res, 32'd0);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      send(OP_SRL, 32'd12, 32'h1234_5678, 32'h0001_2345);
      drain();

      rdy_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom);
         ra = $urandom;
         rb = $urandom;
         send(ro, ra, rb, model(ro, ra, rb));
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      drain();
      rdy_rand = 1'b0;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
